meter_pay_arbiter: RTL and testbench

METER_PAY_ARBITER -- requirements
Module: meter_pay_arbiter

---
 rtl/meter_pkg.sv | 41 ++++
 rtl/meter_sat_cnt.sv | 23 ++
 rtl/meter_pay_arbiter.sv | 111 +++++++++++
 tb/tb_meter_pay_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/meter_pkg.sv
// Shared definitions for the parking-meter payment arbiter: command codes,
// FSM states, pulse-gap default and command decode helpers.
package meter_pkg;

  localparam logic [2:0] CMD_ADD1 = 3'd1;
  localparam logic [2:0] CMD_ADD2 = 3'd2;
  localparam logic [2:0] CMD_ADD3 = 3'd3;
  localparam logic [2:0] CMD_ADD4 = 3'd4;
  localparam logic [2:0] CMD_RST1 = 3'd5;
  localparam logic [2:0] CMD_RST2 = 3'd6;

  localparam int unsigned GAP_DEFAULT = 2;
  localparam int unsigned GAP_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bit order matches {rst2, rst1, add4, add3, add2, add1}.
  function automatic logic [5:0] cmd_onehot(input logic [2:0] cmd);
    logic [5:0] vec;
    vec = '0;
    case (cmd)
      CMD_ADD1: vec = 6'b000001;
      CMD_ADD2: vec = 6'b000010;
      CMD_ADD3: vec = 6'b000100;
      CMD_ADD4: vec = 6'b001000;
      CMD_RST1: vec = 6'b010000;
      CMD_RST2: vec = 6'b100000;
      default:  vec = '0;
    endcase
    return vec;
  endfunction

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return (cmd_onehot(cmd) != '0);
  endfunction

endpackage

// File: rtl/meter_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module meter_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: counters are plain flops and get an explicit reset value; only RAMs skip reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/meter_pay_arbiter.sv
// Round-robin arbiter between two payment kiosks driving one-cycle meter pulses,
// with a programmable idle gap after each pulse and per-kiosk activity counters.
module meter_pay_arbiter
  import meter_pkg::*;
#(
  parameter int unsigned GAP = GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [2:0] a_cmd,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_cmd,
  output logic       b_ready,
  input  logic       hold,
  input  logic       cnt_clr,
  output logic       add1,
  output logic       add2,
  output logic       add3,
  output logic       add4,
  output logic       rst1,
  output logic       rst2,
  output logic       busy,
  output logic       last_grant,
  output logic [7:0] a_count,
  output logic [7:0] b_count,
  output logic [3:0] err_count
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  state_e           state, state_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic             ptr;        // 1 = B favoured when both kiosks request
  logic [5:0]       pulse_q;
  logic             sel_b;
  logic             can_grant;
  logic             hs;
  logic [2:0]       cmd;
  logic             legal;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state;
    gap_d     = gap_cnt;
    can_grant = rst && (state == ST_IDLE) && !hold;
    sel_b     = b_valid && (!a_valid || ptr);
    a_ready   = can_grant && a_valid && !sel_b;
    b_ready   = can_grant && sel_b;
    hs        = a_ready || b_ready;
    cmd       = sel_b ? b_cmd : a_cmd;
    legal     = cmd_legal(cmd);

    case (state)
      ST_IDLE: begin
        if (hs && legal) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        state_d = ST_GAP;
        gap_d   = GAP_LAST;
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_d = ST_IDLE;
        else               gap_d   = gap_cnt - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      ptr        <= 1'b0;
      last_grant <= 1'b0;
      pulse_q    <= '0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_d;
      pulse_q <= (hs && legal) ? cmd_onehot(cmd) : '0;
      if (hs) begin
        ptr        <= !sel_b;
        last_grant <= sel_b;
      end
    end
  end

  assign {rst2, rst1, add4, add3, add2, add1} = pulse_q;
  assign busy = (state != ST_IDLE);

  // last_grant still names the requester throughout PULSE.
  logic a_inc, b_inc, err_inc;
  assign a_inc   = (state == ST_PULSE) && !last_grant;
  assign b_inc   = (state == ST_PULSE) &&  last_grant;
  assign err_inc = hs && !legal;

  meter_sat_cnt #(.W(8)) u_a_cnt (
    .clk(clk), .rst(rst), .inc(a_inc), .clr(cnt_clr), .count(a_count)
  );

  meter_sat_cnt #(.W(8)) u_b_cnt (
    .clk(clk), .rst(rst), .inc(b_inc), .clr(cnt_clr), .count(b_count)
  );

  meter_sat_cnt #(.W(4)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(err_inc), .clr(cnt_clr), .count(err_count)
  );

endmodule

// File: tb/tb_meter_pay_arbiter.sv
// Self-checking bench for meter_pay_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-indexed transaction model.
module tb_meter_pay_arbiter;

  localparam int GAP = 2;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid;
  logic [2:0] a_cmd, b_cmd;
  logic       a_ready, b_ready;
  logic       hold, cnt_clr;
  logic       add1, add2, add3, add4, rst1, rst2;
  logic       busy, last_grant;
  logic [7:0] a_count, b_count;
  logic [3:0] err_count;

  meter_pay_arbiter #(.GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
    .hold(hold), .cnt_clr(cnt_clr),
    .add1(add1), .add2(add2), .add3(add3), .add4(add4), .rst1(rst1), .rst2(rst2),
    .busy(busy), .last_grant(last_grant),
    .a_count(a_count), .b_count(b_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: cycle numbers of the next pulse and of the next free cycle.
  int         cyc;
  int         free_at;
  int         pulse_at;
  logic [5:0] pulse_vec;
  logic       who;
  logic       fav_b;
  logic       last_g;
  int         a_m, b_m, e_m;
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at  = 0;
    pulse_at = -1;
    pulse_vec = '0;
    who      = 1'b0;
    fav_b    = 1'b0;
    last_g   = 1'b0;
    a_m = 0; b_m = 0; e_m = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model, cross the rising edge.
  task automatic tick();
    logic       idle, exp_ar, exp_br, hs, sel;
    logic [2:0] c;
    logic [5:0] ep;
    @(negedge clk);
    idle   = (cyc >= free_at);
    exp_ar = rst && idle && !hold && a_valid && (!b_valid || !fav_b);
    exp_br = rst && idle && !hold && b_valid && (!a_valid || fav_b);
    ep     = (cyc == pulse_at) ? pulse_vec : 6'd0;
    check("a_ready",    {7'd0, a_ready},    {7'd0, exp_ar});
    check("b_ready",    {7'd0, b_ready},    {7'd0, exp_br});
    check("busy",       {7'd0, busy},       {7'd0, !idle});
    check("pulses",     {2'd0, rst2, rst1, add4, add3, add2, add1}, {2'd0, ep});
    check("last_grant", {7'd0, last_grant}, {7'd0, last_g});
    check("a_count",    a_count,            8'(a_m));
    check("b_count",    b_count,            8'(b_m));
    check("err_count",  {4'd0, err_count},  8'(e_m));

    hs  = exp_ar || exp_br;
    sel = exp_br;
    c   = sel ? b_cmd : a_cmd;
    if (!rst) begin
      model_reset();
    end else begin
      if (cnt_clr) begin
        a_m = 0; b_m = 0; e_m = 0;
      end else begin
        if (cyc == pulse_at) begin
          if (who) b_m = (b_m < 255) ? b_m + 1 : 255;
          else     a_m = (a_m < 255) ? a_m + 1 : 255;
        end
        if (hs && !(c >= 3'd1 && c <= 3'd6)) e_m = (e_m < 15) ? e_m + 1 : 15;
      end
      if (hs) begin
        last_g = sel;
        fav_b  = !sel;
        if (c >= 3'd1 && c <= 3'd6) begin
          pulse_at  = cyc + 1;
          pulse_vec = 6'(1 << (int'(c) - 1));
          who       = sel;
          free_at   = cyc + 2 + GAP;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; a_cmd = '0; b_cmd = '0;
    hold = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, with requests present while reset is held.
    a_valid = 1'b1; b_valid = 1'b1; a_cmd = 3'd1; b_cmd = 3'd2;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();

    // Single ADD4 from A: same-cycle ready, pulse one cycle later, busy 1+GAP cycles.
    a_valid = 1'b1; a_cmd = 3'd4;
    tick();
    a_valid = 1'b0;
    repeat (4) tick();
    check("single_a_count", a_count, 8'd1);

    // Both kiosks valid and held after reset: A first, then B.
    do_reset();
    a_valid = 1'b1; a_cmd = 3'd1; b_valid = 1'b1; b_cmd = 3'd2;
    tick();
    check("rr_first_grant", {7'd0, last_grant}, 8'd0);
    repeat (4) tick();
    check("rr_second_grant", {7'd0, last_grant}, 8'd1);
    repeat (4) tick();
    idle_inputs();
    repeat (4) tick();

    // Illegal code from B, then a legal B request served at once.
    b_valid = 1'b1; b_cmd = 3'd7;
    tick();
    b_cmd = 3'd3;
    tick();
    check("illegal_err_count", {4'd0, err_count}, 8'd1);
    b_valid = 1'b0;
    repeat (4) tick();

    // Hold raised the cycle after an RST1 handshake.
    a_valid = 1'b1; a_cmd = 3'd5;
    tick();
    hold = 1'b1;
    repeat (6) tick();
    hold = 1'b0;
    repeat (5) tick();
    idle_inputs();
    tick();

    // Back-to-back A commands saturate a_count; clear coinciding with an increment wins.
    do_reset();
    a_valid = 1'b1; a_cmd = 3'd1;
    repeat (260 * (GAP + 2)) tick();
    check("a_count_saturated", a_count, 8'd255);
    for (int i = 0; i < 2 * (GAP + 2); i++) begin
      if (pulse_at == cyc) begin
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        break;
      end
      tick();
    end
    a_valid = 1'b0;
    tick();
    check("clr_beats_inc", a_count, 8'd0);
    repeat (4) tick();

    // Reset during PULSE, then the first request after release goes to A.
    a_valid = 1'b1; a_cmd = 3'd2;
    tick();
    a_valid = 1'b0; rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_cmd = 3'd3; b_cmd = 3'd4;
    tick();
    check("post_reset_grant", {7'd0, last_grant}, 8'd0);
    idle_inputs();
    repeat (4) tick();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_cmd   = 3'($urandom_range(0, 7));
      b_cmd   = 3'($urandom_range(0, 7));
      hold    = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 199) != 0);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
